// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
// State encoding, grant owner, word width and parameter defaults.
package mem_port_arbiter_pkg;

  localparam int WORD_W        = 32;
  localparam int MEM_LAT_DEF   = 2;
  localparam int MAX_D_RUN_DEF = 4;
  localparam int LAT_W         = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency memory.
// Ports: clk/clr, if_* fetch, dm_* data, stall, mem_* memory side.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int MAX_D_RUN = MAX_D_RUN_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int RUN_W =
    (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(MAX_D_RUN);
  localparam logic [LAT_W-1:0] LAT_LOAD =
    LAT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              pick_dm;

  // Data wins contention until the run counter
  // reaches its limit, then fetch is forced in.
  assign pick_dm =
    dm_req & (~if_req | (run_q != RUN_MAX));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    lat_d      = lat_q;
    run_d      = run_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (if_req | dm_req) begin
          state_d = S_ISSUE;
          if (pick_dm) begin
            gnt_d   = GNT_DM;
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            if (if_req && run_q != RUN_MAX)
              run_d = run_q + RUN_W'(1);
          end else begin
            gnt_d   = GNT_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            run_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        mem_en  = 1'b1;
        lat_d   = LAT_LOAD;
        state_d = (MEM_LAT == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: begin
        // mem_rdata is valid in this cycle; ready
        // and data appear registered next cycle.
        state_d = S_IDLE;
        if (gnt_q == GNT_DM) begin
          dm_ready_d = 1'b1;
          dm_rdata_d = mem_rdata;
        end else begin
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      gnt_q      <= GNT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lat_q      <= '0;
      run_q      <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      lat_q      <= lat_d;
      run_q      <= run_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall     = (if_req & ~if_ready_q) |
                     (dm_req & ~dm_ready_q);

endmodule
